// File: rtl/xdma_pkg.sv
// xdma_pkg: shared definitions for the xdma word-copy DMA engine.
//   - Address/data widths. ADDR_W and DATA_W are taken from the build
//     when already defined; otherwise defaults are supplied here. The DMA
//     word address is ADDR_W-1 bits wide.
//   - Register indices, CTRL/STATUS bit positions and FSM state encoding.
// Optional feature macro: XDMA_FILL_EN (pattern fill mode), consumed by
// xdma_regs.
`ifndef ADDR_W
`define ADDR_W 9
`endif
`ifndef DATA_W
`define DATA_W 32
`endif

package xdma_pkg;
  localparam int AW = `ADDR_W - 1;
  localparam int DW = `DATA_W;

  // Register indices
  localparam int XDMA_SRC  = 0;
  localparam int XDMA_DST  = 1;
  localparam int XDMA_LEN  = 2;
  localparam int XDMA_CTRL = 3;
  localparam int XDMA_PAT  = 4;

  // CTRL write bits
  localparam int CTRL_START = 0;
  localparam int CTRL_FILL  = 1;
  localparam int CTRL_CLEAR = 2;

  // STATUS read bits
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_FILL = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_CAP  = 2'd2,
    S_WR   = 2'd3
  } state_t;
endpackage

// File: rtl/xdma_regs.sv
// xdma_regs: programming register file of the xdma engine.
// Holds SRC/DST/LEN (and PATTERN when XDMA_FILL_EN is defined), the busy
// and sticky done flags, the latched fill mode, and the registered read mux.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   sel, we, addr     peripheral bus access (write when sel&we, read when sel&~we)
//   data_in/data_out  bus write data / registered read data
//   finish            transfer-complete strobe from the FSM
//   start             accepted start (idle only), combinational
//   start_fill        accepted start requesting fill mode
//   busy, fill        current busy flag and fill mode of current/last transfer
//   src_reg, dst_reg, len_reg, pattern   programmed values
// Optional feature macro: XDMA_FILL_EN.
module xdma_regs
  import xdma_pkg::*;
#(
  parameter int RA_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sel,
  input  logic            we,
  input  logic [RA_W-1:0] addr,
  input  logic [DW-1:0]   data_in,
  output logic [DW-1:0]   data_out,
  input  logic            finish,
  output logic            start,
  output logic            start_fill,
  output logic            busy,
  output logic            fill,
  output logic [AW-1:0]   src_reg,
  output logic [AW-1:0]   dst_reg,
  output logic [AW-1:0]   len_reg,
  output logic [DW-1:0]   pattern
);
  logic          wr_en;
  logic          ctrl_wr;
  logic          done;
  logic [DW-1:0] rd_mux;

  assign wr_en   = sel & we;
  assign ctrl_wr = wr_en && (addr == RA_W'(XDMA_CTRL));
  // A start while busy is dropped here, so the FSM only ever sees it idle.
  assign start   = ctrl_wr & data_in[CTRL_START] & ~busy;

`ifdef XDMA_FILL_EN
  assign start_fill = start & data_in[CTRL_FILL];

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern <= '0;
      fill    <= 1'b0;
    end else begin
      if (wr_en && !busy && addr == RA_W'(XDMA_PAT))
        pattern <= data_in;
      if (start)
        fill <= data_in[CTRL_FILL];
    end
  end
`else
  logic unused_data;
  assign unused_data = ^data_in[DW-1:AW];
  assign start_fill  = 1'b0;
  assign fill        = 1'b0;
  assign pattern     = '0;
`endif

  always_comb begin
    rd_mux = '0;
    case (addr)
      RA_W'(XDMA_SRC):  rd_mux = DW'(src_reg);
      RA_W'(XDMA_DST):  rd_mux = DW'(dst_reg);
      RA_W'(XDMA_LEN):  rd_mux = DW'(len_reg);
      RA_W'(XDMA_CTRL): begin
        rd_mux[STAT_BUSY] = busy;
        rd_mux[STAT_DONE] = done;
        rd_mux[STAT_FILL] = fill;
      end
      RA_W'(XDMA_PAT):  rd_mux = pattern;
      default:          rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_reg  <= '0;
      dst_reg  <= '0;
      len_reg  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
    end else begin
      if (wr_en && !busy) begin
        case (addr)
          RA_W'(XDMA_SRC): src_reg <= data_in[AW-1:0];
          RA_W'(XDMA_DST): dst_reg <= data_in[AW-1:0];
          RA_W'(XDMA_LEN): len_reg <= data_in[AW-1:0];
          default: ;
        endcase
      end
      if (start)       busy <= 1'b1;
      else if (finish) busy <= 1'b0;
      // Start dominates clear; completion dominates a simultaneous clear.
      if (start)                                done <= 1'b0;
      else if (finish)                          done <= 1'b1;
      else if (ctrl_wr && data_in[CTRL_CLEAR])  done <= 1'b0;
      if (sel && !we)
        data_out <= rd_mux;
    end
  end
endmodule

// File: rtl/xdma.sv
// xdma: word-copy DMA engine on the shared memory's DMA port.
// Copies LEN words from SRC to DST (or fills DST with PATTERN when
// XDMA_FILL_EN is defined), stalling whenever the controller owns memory.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   sel, we, addr, data_in    register-file bus access
//   data_out                  registered register read data
//   mem_busy                  controller holds the memory this cycle
//   dma_sel, dma_we, dma_addr, dma_data_in   DMA request to the memory
//   dma_data_out              memory read data, valid after a granted read
//   done_irq                  one-cycle completion pulse
// Optional feature macro: XDMA_FILL_EN.
module xdma
  import xdma_pkg::*;
#(
  parameter int RA_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sel,
  input  logic            we,
  input  logic [RA_W-1:0] addr,
  input  logic [DW-1:0]   data_in,
  output logic [DW-1:0]   data_out,
  input  logic            mem_busy,
  output logic            dma_sel,
  output logic            dma_we,
  output logic [AW-1:0]   dma_addr,
  output logic [DW-1:0]   dma_data_in,
  input  logic [DW-1:0]   dma_data_out,
  output logic            done_irq
);
  state_t        state;
  logic [AW-1:0] src, dst, cnt;
  logic [DW-1:0] data_buf;
  logic          zero_pend;
  logic          grant, finish;
  logic          start, start_fill, busy, fill;
  logic [AW-1:0] src_reg, dst_reg, len_reg;
  logic [DW-1:0] pattern;

  xdma_regs #(.RA_W(RA_W)) u_regs (
    .clk        (clk),
    .rst        (rst),
    .sel        (sel),
    .we         (we),
    .addr       (addr),
    .data_in    (data_in),
    .data_out   (data_out),
    .finish     (finish),
    .start      (start),
    .start_fill (start_fill),
    .busy       (busy),
    .fill       (fill),
    .src_reg    (src_reg),
    .dst_reg    (dst_reg),
    .len_reg    (len_reg),
    .pattern    (pattern)
  );

  assign grant       = dma_sel & ~mem_busy;
  assign dma_data_in = data_buf;
  // Completion: last granted write, or the deferred finish of a LEN=0 start.
  assign finish      = zero_pend | ((state == S_WR) & grant & (cnt == AW'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      src       <= '0;
      dst       <= '0;
      cnt       <= '0;
      data_buf  <= '0;
      zero_pend <= 1'b0;
      dma_sel   <= 1'b0;
      dma_we    <= 1'b0;
      dma_addr  <= '0;
      done_irq  <= 1'b0;
    end else begin
      done_irq <= finish;
      case (state)
        S_IDLE: begin
          zero_pend <= 1'b0;
          if (start) begin
            src <= src_reg;
            dst <= dst_reg;
            cnt <= len_reg;
            if (len_reg == '0) begin
              zero_pend <= 1'b1;
            end else if (start_fill) begin
              state    <= S_WR;
              data_buf <= pattern;
              dma_sel  <= 1'b1;
              dma_we   <= 1'b1;
              dma_addr <= dst_reg;
            end else begin
              state    <= S_RD;
              dma_sel  <= 1'b1;
              dma_we   <= 1'b0;
              dma_addr <= src_reg;
            end
          end
        end
        S_RD: begin
          if (grant) begin
            state   <= S_CAP;
            dma_sel <= 1'b0;
          end
        end
        S_CAP: begin
          // Memory registered the read at the granted edge, so data is valid now.
          data_buf <= dma_data_out;
          state    <= S_WR;
          dma_sel  <= 1'b1;
          dma_we   <= 1'b1;
          dma_addr <= dst;
        end
        S_WR: begin
          if (grant) begin
            src <= src + AW'(1);
            dst <= dst + AW'(1);
            cnt <= cnt - AW'(1);
            if (cnt == AW'(1)) begin
              state   <= S_IDLE;
              dma_sel <= 1'b0;
              dma_we  <= 1'b0;
            end else if (fill) begin
              dma_addr <= dst + AW'(1);
            end else begin
              state    <= S_RD;
              dma_we   <= 1'b0;
              dma_addr <= src + AW'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_xdma.sv
// tb_xdma: directed bench for xdma with a memory model and a scoreboard of
// expected DMA reads/writes.
module tb_xdma;
  import xdma_pkg::*;

  localparam int RA_W  = 3;
  localparam int MEM_N = 1 << AW;

  logic            clk = 1'b0;
  logic            rst, sel, we, mem_busy, mem_init;
  logic [RA_W-1:0] addr;
  logic [DW-1:0]   data_in, data_out, dma_data_in, dma_data_out;
  logic            dma_sel, dma_we, done_irq;
  logic [AW-1:0]   dma_addr;

  xdma #(.RA_W(RA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .sel          (sel),
    .we           (we),
    .addr         (addr),
    .data_in      (data_in),
    .data_out     (data_out),
    .mem_busy     (mem_busy),
    .dma_sel      (dma_sel),
    .dma_we       (dma_we),
    .dma_addr     (dma_addr),
    .dma_data_in  (dma_data_in),
    .dma_data_out (dma_data_out),
    .done_irq     (done_irq)
  );

  always #5 clk = ~clk;

  // Shared memory model: DMA port served only when the controller is idle.
  logic [DW-1:0] mem [MEM_N];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < MEM_N; i++) mem[i] <= $urandom;
    end else if (dma_sel && !mem_busy) begin
      if (dma_we) mem[dma_addr] <= dma_data_in;
      else        dma_data_out  <= mem[dma_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;
  int sel_cnt = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;
  wr_t           wr_q[$];
  logic [AW-1:0] rd_q[$];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Monitor: every granted DMA access must match the head of its queue.
  always @(negedge clk) begin
    wr_t e;
    if (dma_sel) sel_cnt++;
    if (!rst && dma_sel && !mem_busy) begin
      if (dma_we) begin
        n_total++;
        assert (wr_q.size() != 0) begin
          n_pass++;
          e = wr_q.pop_front();
          check("wr_addr", DW'(dma_addr), DW'(e.a));
          check("wr_data", dma_data_in, e.d);
        end else $error("FAIL wr_unexpected: observed write to %0h expected none", dma_addr);
      end else begin
        n_total++;
        assert (rd_q.size() != 0) begin
          n_pass++;
          check("rd_addr", DW'(dma_addr), DW'(rd_q.pop_front()));
        end else $error("FAIL rd_unexpected: observed read of %0h expected none", dma_addr);
      end
    end
  end

  task automatic reg_wr(input int a, input logic [DW-1:0] d);
    sel = 1'b1; we = 1'b1; addr = RA_W'(a); data_in = d;
    @(posedge clk); #1;
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic reg_rd(input int a, output logic [DW-1:0] d);
    sel = 1'b1; we = 1'b0; addr = RA_W'(a);
    @(posedge clk); #1;
    sel = 1'b0;
    d = data_out;
  endtask

  task automatic expect_copy(input int s, input int d, input int n);
    for (int i = 0; i < n; i++) begin
      rd_q.push_back(AW'(s + i));
      wr_q.push_back('{a: AW'(d + i), d: mem[AW'(s + i)]});
    end
  endtask

  task automatic check_mem(input int s, input int d, input int n);
    for (int i = 0; i < n; i++)
      check("mem_copy", mem[AW'(d + i)], mem[AW'(s + i)]);
  endtask

  // Cycles from the start write edge to the edge that raised done_irq.
  task automatic wait_irq(input int c0, input int budget, output int k);
    int n;
    n = 0;
    while (!done_irq && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    k = cyc - c0;
  endtask

  task automatic check_pulse_ends();
    @(posedge clk); #1;
    check("irq_single", DW'(done_irq), 0);
  endtask

  initial begin
    logic [DW-1:0] r, saved;
    int c0, k, s0, n;

    rst = 1'b1; sel = 1'b0; we = 1'b0; addr = '0; data_in = '0;
    mem_busy = 1'b0; mem_init = 1'b1;
    @(posedge clk); #1;
    mem_init = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset state
    check("rst_dma_sel", DW'(dma_sel), 0);
    check("rst_irq", DW'(done_irq), 0);
    reg_rd(XDMA_CTRL, r); check("rst_status", r, 0);
    reg_rd(XDMA_LEN, r);  check("rst_len", r, 0);
    reg_wr(5, 32'h1234);
    reg_rd(5, r);         check("unmapped_read", r, 0);

    // Single uncontended copy
    reg_wr(XDMA_SRC, 32'h10);
    reg_wr(XDMA_DST, 32'h40);
    reg_wr(XDMA_LEN, 32'h4);
    expect_copy(32'h10, 32'h40, 4);
    reg_wr(XDMA_CTRL, 32'h1); c0 = cyc;
    reg_rd(XDMA_CTRL, r); check("status_busy", r, 32'h1);
    wait_irq(c0, 40, k);  check("copy_latency", k, 12);
    check_pulse_ends();
    reg_rd(XDMA_CTRL, r); check("status_done", r, 32'h2);
    check("copy_wr_drained", wr_q.size(), 0);
    check_mem(32'h10, 32'h40, 4);
    reg_rd(XDMA_SRC, r);  check("src_kept", r, 32'h10);
    reg_wr(XDMA_CTRL, 32'h4);
    reg_rd(XDMA_CTRL, r); check("clear_done", r, 0);

    // Contended copy: 3 stalled RD cycles then 2 stalled WR cycles
    reg_wr(XDMA_DST, 32'h48);
    expect_copy(32'h10, 32'h48, 4);
    reg_wr(XDMA_CTRL, 32'h1); c0 = cyc;
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("rd_stall_sel", DW'(dma_sel), 1);
      check("rd_stall_addr", DW'(dma_addr), 32'h10);
      check("rd_stall_we", DW'(dma_we), 0);
      @(posedge clk); #1;
    end
    mem_busy = 1'b0;
    n = 0;
    while (!(dma_sel && dma_we) && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_wr", DW'(dma_we), 1);
    mem_busy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check("wr_stall_addr", DW'(dma_addr), 32'h48);
      check("wr_stall_we", DW'(dma_we), 1);
      check("wr_stall_data", dma_data_in, mem[AW'(32'h10)]);
      @(posedge clk); #1;
    end
    mem_busy = 1'b0;
    wait_irq(c0, 60, k);  check("contend_latency", k, 17);
    check_mem(32'h10, 32'h48, 4);

    // LEN = 0: no memory access, done one cycle after the start
    reg_wr(XDMA_LEN, 32'h0);
    s0 = sel_cnt;
    reg_wr(XDMA_CTRL, 32'h1); c0 = cyc;
    wait_irq(c0, 10, k);  check("len0_latency", k, 1);
    check_pulse_ends();
    check("len0_no_sel", sel_cnt, s0);
    reg_rd(XDMA_CTRL, r); check("len0_status", r, 32'h2);

    // Busy protection, with start+clear in one write (start wins)
    reg_wr(XDMA_SRC, 32'h30);
    reg_wr(XDMA_DST, 32'h60);
    reg_wr(XDMA_LEN, 32'h4);
    expect_copy(32'h30, 32'h60, 4);
    reg_wr(XDMA_CTRL, 32'h5); c0 = cyc;
    reg_rd(XDMA_CTRL, r); check("start_clear", r, 32'h1);
    reg_wr(XDMA_LEN, 32'h9);
    reg_wr(XDMA_SRC, 32'h77);
    reg_wr(XDMA_CTRL, 32'h1);
    wait_irq(c0, 40, k);  check("busy_latency", k, 12);
    reg_rd(XDMA_LEN, r);  check("len_protected", r, 32'h4);
    reg_rd(XDMA_SRC, r);  check("src_protected", r, 32'h30);
    check("busy_wr_drained", wr_q.size(), 0);
    check_mem(32'h30, 32'h60, 4);

    // Address wrap on the source
    reg_wr(XDMA_SRC, MEM_N - 1);
    reg_wr(XDMA_DST, 32'h80);
    reg_wr(XDMA_LEN, 32'h2);
    expect_copy(MEM_N - 1, 32'h80, 2);
    reg_wr(XDMA_CTRL, 32'h1); c0 = cyc;
    wait_irq(c0, 30, k);  check("wrap_latency", k, 6);
    check("wrap_rd_drained", rd_q.size(), 0);
    check_mem(MEM_N - 1, 32'h80, 2);

    // Reset while a write is pending
    reg_wr(XDMA_DST, 32'h90);
    reg_wr(XDMA_LEN, 32'h4);
    expect_copy(MEM_N - 1, 32'h90, 4);
    saved = mem[AW'(32'h90)];
    reg_wr(XDMA_CTRL, 32'h1);
    n = 0;
    while (!(dma_sel && dma_we) && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("rst_reach_wr", DW'(dma_we), 1);
    mem_busy = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_busy = 1'b0;
    wr_q.delete(); rd_q.delete();
    check("rst_mid_sel", DW'(dma_sel), 0);
    s0 = sel_cnt;
    reg_rd(XDMA_CTRL, r); check("rst_mid_status", r, 0);
    repeat (5) @(posedge clk);
    #1;
    check("rst_mid_no_sel", sel_cnt, s0);
    check("rst_mid_no_write", mem[AW'(32'h90)], saved);

`ifdef XDMA_FILL_EN
    // Pattern fill
    reg_wr(XDMA_PAT, 32'hA5);
    reg_wr(XDMA_DST, 32'h20);
    reg_wr(XDMA_LEN, 32'h3);
    for (int i = 0; i < 3; i++) wr_q.push_back('{a: AW'(32'h20 + i), d: 32'hA5});
    reg_wr(XDMA_CTRL, 32'h3); c0 = cyc;
    wait_irq(c0, 20, k);  check("fill_latency", k, 3);
    for (int i = 0; i < 3; i++) check("fill_mem", mem[AW'(32'h20 + i)], 32'hA5);
    reg_rd(XDMA_CTRL, r); check("fill_status", r, 32'h6);
    reg_rd(XDMA_PAT, r);  check("fill_pattern", r, 32'hA5);
`else
    reg_wr(XDMA_PAT, 32'hA5);
    reg_rd(XDMA_PAT, r);  check("no_pattern_reg", r, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/xdma.md
Name: xdma

Overview:
- Word-copy DMA engine that drives the shared memory's DMA data port: dma_sel, dma_we, dma_addr, dma_data_in and dma_data_out.
- It is programmed by the controller through a small register file on the peripheral bus, then copies LEN words from SRC to DST inside the memory.
- The memory gives its port to the controller whenever the controller's data_sel is high, so xdma stalls cycle-by-cycle on contention.

Parameters:
- RA_W, 3, register-file address width.
- Address width is `ADDR_W-1 and data width is `DATA_W, both from xdefs.vh.

Ports:
- clk  in  1  system clock; every flop is updated on posedge clk.
- rst  in  1  synchronous, active-high reset.
- sel  in  1  register-file select from the controller.
- we  in  1  register write enable; qualified by sel.
- addr  in  RA_W  register index.
- data_in  in  `DATA_W  register write data.
- data_out  out  `DATA_W  register read data, registered.
- mem_busy  in  1  the controller's memory data_sel; when 1, the memory ignores the DMA port.
- dma_sel  out  1  DMA request and enable to the memory.
- dma_we  out  1  DMA write enable.
- dma_addr  out  `ADDR_W-1  DMA word address.
- dma_data_in  out  `DATA_W  write data to the memory.
- dma_data_out  in  `DATA_W  memory read data, valid the cycle after a granted read.
- done_irq  out  1  single-cycle pulse when a transfer completes.

Behaviour:
- Register map:
  - 0 SRC, 1 DST, 2 LEN (each `ADDR_W-1 bits, zero-extended on read).
  - 3 CTRL/STATUS. Write: bit0 start, bit1 fill (see optional feature), bit2 clear done. Read: bit0 busy, bit1 done.
  - 4 PATTERN (only with the optional feature). Other addresses read 0; writes to them are ignored.
- Reads: data_out <= reg[addr] on any cycle with sel=1 and we=0; data_out holds otherwise. Read latency is 1 cycle.
- Writes to SRC, DST, LEN or PATTERN while busy are ignored. A start while busy is ignored.
- Grant is defined as dma_sel and not mem_busy.
- FSM states are IDLE, RD, CAP, WR.
- IDLE:
  - On start: take src/dst/cnt from SRC/DST/LEN, set busy, clear done.
  - Go to RD, or to WR if fill is selected.
  - If LEN is 0: go nowhere, and on the next cycle set done and pulse done_irq with no memory access.
- RD: dma_sel=1, dma_we=0, dma_addr=src. Stay while not granted; go to CAP on grant.
- CAP: dma_sel=0; buf <= dma_data_out; go to WR. The capture is unconditional, because data_out was registered at the granted edge.
- WR: dma_sel=1, dma_we=1, dma_addr=dst, dma_data_in=buf.
  - While not granted: stay, holding all outputs stable.
  - On grant: src+1, dst+1, cnt-1.
  - If cnt was 1: go to IDLE, clear busy, set done, pulse done_irq for 1 cycle. Otherwise go to RD.
- Throughput is 3 cycles per word uncontended, plus 1 extra cycle for each contended RD or WR cycle.
- Addresses wrap modulo 2^(`ADDR_W-1). The copy is forward-only; overlapping regions are not corrected.
- SRC, DST and LEN registers keep their programmed values; the working copies are internal.
- done is sticky. It is cleared by a CTRL write with bit2=1 or by a new start. If start and clear are written in the same cycle, start wins and done stays 0.
- Reset values: all outputs, registers, buf and FSM go to 0/IDLE. Reset mid-transfer aborts immediately; no partial write is issued after reset.

Optional Feature:
- Macro: XDMA_FILL_EN.
- Defined:
  - PATTERN register exists.
  - Start with CTRL bit1=1 skips RD/CAP and writes PATTERN to LEN words at DST, at 1 cycle per uncontended word. SRC is untouched.
  - STATUS read bit2 reflects the fill mode of the current or last transfer.
- Undefined:
  - CTRL bit1 is ignored and every transfer is a copy.
  - Address 4 reads 0 and STATUS bit2 reads 0.

Decomposition:
- Shared package/header xdma_defs.vh:
  - Register indices (XDMA_SRC=0, XDMA_DST=1, XDMA_LEN=2, XDMA_CTRL=3, XDMA_PAT=4).
  - CTRL bit positions.
  - FSM state encodings (2 bits).
- One natural sub-module, xdma_regs: the register file, the read mux and the done/start latching. xdma keeps the FSM and the address counters.

Test Plan:
- Single copy: SRC=0x10, DST=0x40, LEN=4, start, mem_busy=0 -> mem[0x40..0x43]=mem[0x10..0x13]; done_irq pulses exactly 12 cycles after the start write; STATUS=0b10.
- Contention: same copy with mem_busy=1 for 3 cycles during RD and 2 during WR -> correct data; completion delayed by exactly 5 cycles; dma_addr/dma_we are stable across the stalls.
- LEN=0 start -> dma_sel never asserts; done_irq pulses 1 cycle after the start write; done=1.
- Wrap: SRC=2^(`ADDR_W-1)-1, LEN=2 -> reads that address then address 0.
- Busy protection: write LEN=9 and start again mid-transfer -> both ignored; the original LEN=4 completes and LEN reads back 4.
- Reset mid-WR -> dma_sel=0, busy=0 and done=0 next cycle. With XDMA_FILL_EN: PATTERN=0xA5, DST=0x20, LEN=3, fill start -> 0x20..0x22=0xA5 after 3 cycles.
